signed_seq_divider: RTL
=======================

Name: signed_seq_divider

Overview:
- Sequential signed divider; the inverse of the team's 9x9 Karatsuba multiplier.
- Takes a 17-bit two's-complement dividend (product width) and a 9-bit two's-complement divisor (operand width).
- Produces a 9-bit quotient and a 9-bit remainder, truncating toward zero.
- Used to check products and to recover an operand from a product. Runs a restoring radix-2 loop on magnitudes, with a start/done handshake matching the multiplier control unit.

Parameters:
- N_W, 17, dividend width (two's complement)
- D_W, 9, divisor/quotient/remainder width (two's complement)

Ports:
- clock  in  1  single system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs
- start  in  1  request; sampled only in IDLE
- a  in  N_W  dividend, two's complement
- b  in  D_W  divisor, two's complement
- quotient  out  D_W  signed quotient (low D_W bits of the true quotient)
- remainder  out  D_W  signed remainder; sign follows the dividend
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; results are valid from this cycle on
- div_by_zero  out  1  sticky until next accepted start
- overflow  out  1  true quotient outside [-256,255]; sticky until next accepted start

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset asserted mid-operation aborts at once; no done pulse follows.
- States (4-bit encoding): IDLE=0, ITER=1, FIX=2, DONE=3.
- IDLE with start=1:
  - Latch |a| (17-bit magnitude; -65536 gives 0x10000), |b|, sa=a[16] and sb=b[8].
  - Clear flags; clear the partial remainder (10 bits) and the quotient shift register (17 bits); load the step counter with 16.
  - If b==0: set div_by_zero, set quotient=0 and remainder=0, go to DONE. Otherwise go to ITER.
- ITER, one bit per cycle, MSB first:
  - Shift the next dividend bit into the partial remainder.
  - Compute trial = partial - |b|. If trial >= 0, keep trial and shift in q=1; else shift in q=0.
  - Counter decrements each cycle; on count 0 go to FIX. ITER lasts exactly 17 cycles.
- FIX:
  - quotient = (sa^sb) ? -qmag : qmag, truncated to D_W.
  - remainder = sa ? -rmag : rmag.
  - overflow=1 when qmag > 255 with sa==sb, or qmag > 256 with sa!=sb.
  - Go to DONE.
- DONE: done=1 for one cycle, then return to IDLE unconditionally.
- Latency:
  - Normal division: done is high in the cycle after the 19th rising edge following the edge that sampled start.
  - Divide by zero: done is high after the 1st such edge.
- start outside IDLE is ignored; a and b may change freely after the sampling edge.
- quotient, remainder and the flags hold their values until the next accepted start, FIX or reset.
- Magnitude arithmetic is unsigned, with one guard bit on the partial remainder. Since rmag < |b| <= 256, rmag is at most 255, so the remainder always fits in D_W.

Optional Feature:
- DIVIDER_STATE_PORT_EN:
  - When defined, adds output port state [3:0] driving the current state encoding, for bench observation (same style as the multiplier).
  - When undefined, the port does not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/include div_pkg holds:
  - N_W, D_W
  - the state encodings IDLE/ITER/FIX/DONE
  - the ITER cycle count (N_W)
- One natural sub-module: div_step. It is purely combinational: partial remainder, next dividend bit and |b| in; next partial remainder and quotient bit out.
- The FSM, counter and sign fix stay in the top module.

Test Plan:
- a=17'h03039 (12345), b=9'h064 (100), start pulse -> after 19 edges done=1, quotient=9'h07B (123), remainder=9'h02D (45), flags 0.
- a=17'h1CFC7 (-12345), b=9'h064 -> quotient=9'h185 (-123), remainder=9'h1D3 (-45).
- a=17'h101FF (-65025, multiplier product of 9'h101 and 9'h0FF), b=9'h0FF -> quotient=9'h101 (-255), remainder=0, overflow=0.
- a=17'h10000 (-65536), b=9'h100 (-256) -> overflow=1, quotient=9'h100; b=0 with any a -> done after 1 edge, div_by_zero=1, quotient=0, remainder=0.
- Assert reset during ITER cycle 8 -> outputs 0 and IDLE immediately, no done. Pulse start during ITER -> ignored, latency unchanged.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the signed sequential divider.
//   N_W      : dividend width (two's complement, product width of the 9x9 multiplier)
//   D_W      : divisor / quotient / remainder width (two's complement)
//   ITER_CNT : number of ITER cycles, one per dividend bit
//   CNT_W    : width of the ITER step down-counter
package div_pkg;

   localparam int N_W      = 17;
   localparam int D_W      = 9;
   localparam int ITER_CNT = N_W;
   localparam int CNT_W    = 5;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      ITER = 4'd1,
      FIX  = 4'd2,
      DONE = 4'd3
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step on unsigned magnitudes.
// Ports:
//   rem_i   : current partial remainder (D_W+1 bits, top bit is a guard bit)
//   bit_i   : next dividend bit, MSB first
//   dvsr_i  : divisor magnitude |b| (D_W bits, up to 2**(D_W-1))
//   rem_o   : next partial remainder
//   qbit_o  : quotient bit produced by this step
module div_step
   import div_pkg::*;
(
   input  logic [D_W:0]   rem_i,
   input  logic           bit_i,
   input  logic [D_W-1:0] dvsr_i,
   output logic [D_W:0]   rem_o,
   output logic           qbit_o
);

   logic [D_W:0]   shifted;
   logic [D_W+1:0] trial;

   // rem_i < |b| <= 256 so its guard bit is always clear; dropping it loses nothing.
   assign shifted = {rem_i[D_W-1:0], bit_i};
   // One extra bit so the sign of the trial subtraction is visible.
   assign trial   = {1'b0, shifted} - {2'b00, dvsr_i};

   always_comb begin
      rem_o  = shifted;
      qbit_o = 1'b0;
      if (!trial[D_W+1]) begin
         rem_o  = trial[D_W:0];
         qbit_o = 1'b1;
      end
   end

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential signed divider (truncating toward zero): 17-bit dividend by
// 9-bit divisor, 9-bit quotient and remainder, start/done handshake.
// Optional build macro: DIVIDER_STATE_PORT_EN adds output state[3:0]
// showing the current FSM encoding.
// Ports:
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-high; forces IDLE and clears outputs
//   start       : request, sampled only in IDLE
//   a           : dividend, two's complement, N_W bits
//   b           : divisor, two's complement, D_W bits
//   quotient    : signed quotient (low D_W bits of true quotient)
//   remainder   : signed remainder, sign follows the dividend
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse, results valid from this cycle on
//   div_by_zero : sticky until next accepted start
//   overflow    : true quotient outside [-256,255], sticky until next accepted start
//
// state | meaning
// IDLE  | waiting for start; results held
// ITER  | one restoring step per cycle, 17 cycles, dividend MSB first
// FIX   | apply signs to magnitudes, evaluate overflow
// DONE  | raise done for the following cycle, return to IDLE
module signed_seq_divider
   import div_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [N_W-1:0] a,
   input  logic [D_W-1:0] b,
   output logic [D_W-1:0] quotient,
   output logic [D_W-1:0] remainder,
   output logic           busy,
   output logic           done,
   output logic           div_by_zero,
   output logic           overflow
`ifdef DIVIDER_STATE_PORT_EN
   ,
   output logic [3:0]     state
`endif
);

   state_t         state_q;
   logic [N_W-1:0] a_mag_q;
   logic [D_W-1:0] b_mag_q;
   logic           sa_q;
   logic           sb_q;
   logic [D_W:0]   rem_q;
   logic [N_W-1:0] q_sh_q;
   logic [CNT_W-1:0] cnt_q;

   logic [D_W-1:0] quotient_q;
   logic [D_W-1:0] remainder_q;
   logic           busy_q;
   logic           done_q;
   logic           dbz_q;
   logic           ovf_q;

   logic [N_W-1:0] a_mag_d;
   logic [D_W-1:0] b_mag_d;
   logic [D_W:0]   rem_d;
   logic           qbit_d;
   logic [D_W-1:0] q_lo;
   logic [D_W-1:0] r_lo;

   // -65536 maps to 0x10000, which fits the unsigned 17-bit magnitude.
   assign a_mag_d = a[N_W-1] ? (~a + 1'b1) : a;
   assign b_mag_d = b[D_W-1] ? (~b + 1'b1) : b;

   div_step u_step (
      .rem_i  (rem_q),
      .bit_i  (a_mag_q[N_W-1]),
      .dvsr_i (b_mag_q),
      .rem_o  (rem_d),
      .qbit_o (qbit_d)
   );

   assign q_lo = q_sh_q[D_W-1:0];
   assign r_lo = rem_q[D_W-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         a_mag_q     <= '0;
         b_mag_q     <= '0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         rem_q       <= '0;
         q_sh_q      <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_mag_q <= a_mag_d;
                  b_mag_q <= b_mag_d;
                  sa_q    <= a[N_W-1];
                  sb_q    <= b[D_W-1];
                  rem_q   <= '0;
                  q_sh_q  <= '0;
                  cnt_q   <= CNT_W'(ITER_CNT - 1);
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  if (b == '0) begin
                     dbz_q       <= 1'b1;
                     quotient_q  <= '0;
                     remainder_q <= '0;
                     state_q     <= DONE;
                  end else begin
                     dbz_q   <= 1'b0;
                     state_q <= ITER;
                  end
               end
            end
            ITER: begin
               rem_q   <= rem_d;
               q_sh_q  <= {q_sh_q[N_W-2:0], qbit_d};
               a_mag_q <= {a_mag_q[N_W-2:0], 1'b0};
               cnt_q   <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               // Negating the low bits equals the low bits of the negation.
               quotient_q  <= (sa_q ^ sb_q) ? (~q_lo + 1'b1) : q_lo;
               remainder_q <= sa_q ? (~r_lo + 1'b1) : r_lo;
               // A negative result may reach -256; a positive one only 255.
               ovf_q   <= (sa_q == sb_q) ? (q_sh_q > N_W'(255)) : (q_sh_q > N_W'(256));
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

`ifdef DIVIDER_STATE_PORT_EN
   assign state = state_q;
`endif

endmodule
